sorted_order_book: RTL

- Price-time-priority limit order book for NUM_STOCKS instruments, one bid side and one ask side per stock.
- Each side is a register array kept sorted at all times, so the best price is always entry 0 and is exported with no scan.
- Accepts ADD/CANCEL/EXECUTE commands from the feed decoder over a valid/ready handshake and returns one status response per command.
- Drives per-stock top-of-book to the trading logic.

---
 rtl/order_book_pkg.sv | 44 ++++
 rtl/book_side.sv | 103 ++++++++++
 rtl/sorted_order_book.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/order_book_pkg.sv
// Shared types for the sorted order book: command/status codes, the resting
// order entry layout, FSM states and the per-side update operation.
package order_book_pkg;

  localparam int unsigned PRICE_W = 32;
  localparam int unsigned QTY_W   = 16;
  localparam int unsigned ID_W    = 32;

  typedef enum logic [1:0] {
    CMD_ADD     = 2'd0,
    CMD_CANCEL  = 2'd1,
    CMD_EXECUTE = 2'd2,
    CMD_RSVD    = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    STS_OK        = 3'd0,
    STS_FULL      = 3'd1,
    STS_NOT_FOUND = 3'd2,
    STS_BAD_QTY   = 3'd3,
    STS_BAD_STOCK = 3'd4,
    STS_BAD_CMD   = 3'd5
  } status_t;

  typedef struct packed {
    logic [QTY_W-1:0]   qty;
    logic [PRICE_W-1:0] price;
    logic [ID_W-1:0]    id;
  } order_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_INSERT = 2'd1,
    OP_REMOVE = 2'd2,
    OP_MODIFY = 2'd3
  } side_op_t;

endpackage

// File: rtl/book_side.sv
// One side (bid or ask) of one instrument, kept sorted best-first.
// Ports: lookup_price/lookup_id -> ins_idx, match_found/idx/qty (combinational
// lookup); wr_en/wr_op/wr_idx/wr_entry apply one update per cycle;
// best_price/best_qty/count expose entry 0 and the resting count;
// top_change_c flags that the pending update alters entry 0 price or qty.
module book_side
  import order_book_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter bit          IS_BID = 1'b1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [PRICE_W-1:0] lookup_price,
  input  logic [ID_W-1:0]    lookup_id,
  output logic [CNT_W-1:0]   ins_idx,
  output logic               match_found,
  output logic [CNT_W-1:0]   match_idx,
  output logic [QTY_W-1:0]   match_qty,
  input  logic               wr_en,
  input  side_op_t           wr_op,
  input  logic [CNT_W-1:0]   wr_idx,
  input  order_entry_t       wr_entry,
  output logic [PRICE_W-1:0] best_price,
  output logic [QTY_W-1:0]   best_qty,
  output logic [CNT_W-1:0]   count,
  output logic               top_change_c
);

  order_entry_t             entries [DEPTH];
  order_entry_t             nxt     [DEPTH];
  logic         [CNT_W-1:0] nxt_count;

  assign best_price = entries[0].price;
  assign best_qty   = entries[0].qty;

  // Insert point: first valid entry strictly worse than the new price, else append.
  always_comb begin
    ins_idx = count;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (CNT_W'(i) < count) begin
        if (IS_BID ? (entries[i].price < lookup_price)
                   : (entries[i].price > lookup_price))
          ins_idx = CNT_W'(i);
      end
    end
  end

  // Lowest-index id match among valid entries.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    match_qty   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count) && (entries[i].id == lookup_id)) begin
        match_found = 1'b1;
        match_idx   = CNT_W'(i);
        match_qty   = entries[i].qty;
      end
    end
  end

  // Next array image for the requested shift/modify.
  always_comb begin
    nxt       = entries;
    nxt_count = count;
    case (wr_op)
      OP_INSERT: begin
        for (int i = 1; i < int'(DEPTH); i++)
          if (CNT_W'(i) > wr_idx) nxt[i] = entries[i-1];
        for (int i = 0; i < int'(DEPTH); i++)
          if (CNT_W'(i) == wr_idx) nxt[i] = wr_entry;
        nxt_count = count + CNT_W'(1);
      end
      OP_REMOVE: begin
        for (int i = 0; i < int'(DEPTH) - 1; i++)
          if (CNT_W'(i) >= wr_idx) nxt[i] = entries[i+1];
        nxt[DEPTH-1] = '0;
        nxt_count    = count - CNT_W'(1);
      end
      OP_MODIFY: begin
        for (int i = 0; i < int'(DEPTH); i++)
          if (CNT_W'(i) == wr_idx) nxt[i].qty = wr_entry.qty;
      end
      default: ;
    endcase
  end

  assign top_change_c = wr_en && ((nxt[0].price != entries[0].price) ||
                                  (nxt[0].qty   != entries[0].qty));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) entries[i] <= '0;
      count <= '0;
    end else if (wr_en) begin
      entries <= nxt;
      count   <= nxt_count;
    end
  end

endmodule

// File: rtl/sorted_order_book.sv
// Price-time-priority order book for NUM_STOCKS instruments.
// Ports: i_valid/o_ready command handshake with i_cmd/i_side/i_stock_id/
// i_price/i_qty/i_order_id; o_rsp_valid/o_rsp_status one response per
// command; per-stock packed top-of-book, counts and o_tob_changed pulses.
// Price/qty/id widths come from order_book_pkg.
module sorted_order_book
  import order_book_pkg::*;
#(
  parameter int unsigned NUM_STOCKS = 4,
  parameter int unsigned BOOK_DEPTH = 8,
  localparam int unsigned SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  localparam int unsigned CNT_W = $clog2(BOOK_DEPTH + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [1:0]                    i_cmd,
  input  logic                          i_side,
  input  logic [SID_W-1:0]              i_stock_id,
  input  logic [PRICE_W-1:0]            i_price,
  input  logic [QTY_W-1:0]              i_qty,
  input  logic [ID_W-1:0]               i_order_id,
  output logic                          o_rsp_valid,
  output logic [2:0]                    o_rsp_status,
  output logic [NUM_STOCKS*PRICE_W-1:0] o_best_bid_price,
  output logic [NUM_STOCKS*QTY_W-1:0]   o_best_bid_qty,
  output logic [NUM_STOCKS*PRICE_W-1:0] o_best_ask_price,
  output logic [NUM_STOCKS*QTY_W-1:0]   o_best_ask_qty,
  output logic [NUM_STOCKS*CNT_W-1:0]   o_bid_count,
  output logic [NUM_STOCKS*CNT_W-1:0]   o_ask_count,
  output logic [NUM_STOCKS-1:0]         o_tob_changed
);

  state_t             state;
  cmd_t               cmd_q;
  logic               side_q;
  logic [SID_W-1:0]   stock_q;
  logic [PRICE_W-1:0] price_q;
  logic [QTY_W-1:0]   qty_q;
  logic [ID_W-1:0]    id_q;
  side_op_t           op_q;
  logic [CNT_W-1:0]   idx_q;
  order_entry_t       entry_q;

  // Per-instance results, indexed [stock][side], side 1 = bid.
  logic [CNT_W-1:0]   ins_idx_a   [NUM_STOCKS][2];
  logic               found_a     [NUM_STOCKS][2];
  logic [CNT_W-1:0]   match_idx_a [NUM_STOCKS][2];
  logic [QTY_W-1:0]   match_qty_a [NUM_STOCKS][2];
  logic [CNT_W-1:0]   count_a     [NUM_STOCKS][2];
  logic               chg_a       [NUM_STOCKS][2];
  logic [NUM_STOCKS-1:0] tob_chg_c;

  logic               stock_bad;
  logic [SID_W-1:0]   sid_sel;
  status_t            status_c;
  side_op_t           op_c;
  logic [CNT_W-1:0]   idx_c;
  logic [QTY_W-1:0]   qty_c;

  assign stock_bad = (32'(stock_q) >= NUM_STOCKS);
  assign sid_sel   = stock_bad ? '0 : stock_q;

  for (genvar s = 0; s < int'(NUM_STOCKS); s++) begin : g_stock
    for (genvar j = 0; j < 2; j++) begin : g_side
      logic wr_en;
      assign wr_en = (state == ST_APPLY) && (op_q != OP_NONE) &&
                     (stock_q == SID_W'(s)) && (side_q == 1'(j));
      logic [PRICE_W-1:0] bp;
      logic [QTY_W-1:0]   bq;
      book_side #(.DEPTH(BOOK_DEPTH), .IS_BID(j == 1)) u_side (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .lookup_price (price_q),
        .lookup_id    (id_q),
        .ins_idx      (ins_idx_a[s][j]),
        .match_found  (found_a[s][j]),
        .match_idx    (match_idx_a[s][j]),
        .match_qty    (match_qty_a[s][j]),
        .wr_en        (wr_en),
        .wr_op        (op_q),
        .wr_idx       (idx_q),
        .wr_entry     (entry_q),
        .best_price   (bp),
        .best_qty     (bq),
        .count        (count_a[s][j]),
        .top_change_c (chg_a[s][j])
      );
      if (j == 1) begin : g_bid
        assign o_best_bid_price[s*PRICE_W +: PRICE_W] = bp;
        assign o_best_bid_qty[s*QTY_W +: QTY_W]       = bq;
        assign o_bid_count[s*CNT_W +: CNT_W]          = count_a[s][j];
      end else begin : g_ask
        assign o_best_ask_price[s*PRICE_W +: PRICE_W] = bp;
        assign o_best_ask_qty[s*QTY_W +: QTY_W]       = bq;
        assign o_ask_count[s*CNT_W +: CNT_W]          = count_a[s][j];
      end
    end
    assign tob_chg_c[s] = chg_a[s][0] | chg_a[s][1];
  end

  // Status and update decision from the captured command and lookup results.
  always_comb begin
    status_c = STS_OK;
    op_c     = OP_NONE;
    idx_c    = '0;
    qty_c    = qty_q;
    if (cmd_q == CMD_RSVD) begin
      status_c = STS_BAD_CMD;
    end else if (stock_bad) begin
      status_c = STS_BAD_STOCK;
    end else begin
      case (cmd_q)
        CMD_ADD: begin
          if (count_a[sid_sel][side_q] == CNT_W'(BOOK_DEPTH)) status_c = STS_FULL;
          else if (qty_q == '0) status_c = STS_BAD_QTY;
          else begin
            op_c  = OP_INSERT;
            idx_c = ins_idx_a[sid_sel][side_q];
          end
        end
        CMD_CANCEL: begin
          if (!found_a[sid_sel][side_q]) status_c = STS_NOT_FOUND;
          else begin
            op_c  = OP_REMOVE;
            idx_c = match_idx_a[sid_sel][side_q];
          end
        end
        default: begin
          idx_c = match_idx_a[sid_sel][side_q];
          qty_c = match_qty_a[sid_sel][side_q] - qty_q;
          if (!found_a[sid_sel][side_q]) status_c = STS_NOT_FOUND;
          else if ((qty_q == '0) || (qty_q > match_qty_a[sid_sel][side_q]))
            status_c = STS_BAD_QTY;
          else if (qty_q == match_qty_a[sid_sel][side_q]) op_c = OP_REMOVE;
          else op_c = OP_MODIFY;
        end
      endcase
    end
  end

  // Command FSM: IDLE accepts, LOOKUP decides and responds, APPLY writes.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= ST_IDLE;
      o_ready       <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_status  <= STS_OK;
      o_tob_changed <= '0;
      cmd_q         <= CMD_ADD;
      side_q        <= 1'b0;
      stock_q       <= '0;
      price_q       <= '0;
      qty_q         <= '0;
      id_q          <= '0;
      op_q          <= OP_NONE;
      idx_q         <= '0;
      entry_q       <= '0;
    end else begin
      o_rsp_valid   <= 1'b0;
      o_tob_changed <= '0;
      case (state)
        ST_IDLE: begin
          if (i_valid && o_ready) begin
            cmd_q   <= cmd_t'(i_cmd);
            side_q  <= i_side;
            stock_q <= i_stock_id;
            price_q <= i_price;
            qty_q   <= i_qty;
            id_q    <= i_order_id;
            o_ready <= 1'b0;
            state   <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          o_rsp_valid  <= 1'b1;
          o_rsp_status <= status_c;
          op_q         <= op_c;
          idx_q        <= idx_c;
          entry_q      <= '{qty: qty_c, price: price_q, id: id_q};
          state        <= ST_APPLY;
        end
        ST_APPLY: begin
          o_tob_changed <= tob_chg_c;
          o_ready       <= 1'b1;
          op_q          <= OP_NONE;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
